// File: rtl/ppu_pkg.sv
// Shared PPU output timing constants, palette address helpers and the NES colour table.
package ppu_pkg;

  localparam logic [8:0] CYCLES      = 9'd341;
  localparam logic [8:0] LINES       = 9'd262;
  localparam logic [8:0] VIS_LINES   = 9'd240;
  localparam logic [8:0] VIS_W       = 9'd256;
  localparam logic [8:0] HSYNC_START = 9'd280;
  localparam logic [8:0] HSYNC_END   = 9'd304;
  localparam logic [8:0] VSYNC_START = 9'd243;
  localparam logic [8:0] VSYNC_END   = 9'd245;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       hs;
    logic       vs;
    logic       fs;
  } pix_tag_t;

  // Sprite palette entry 0 of each group aliases the matching background entry.
  function automatic logic [4:0] pal_mirror(input logic [4:0] a);
    return (a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
  endfunction

  // Colour 0 of any palette shows the shared backdrop.
  function automatic logic [4:0] pal_lookup(input logic [4:0] idx);
    return (idx[1:0] == 2'b00) ? 5'd0 : idx;
  endfunction

  localparam logic [23:0] NES_RGB [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };

endpackage

// File: rtl/nes_rgb_rom.sv
// Registered NES colour code to 24-bit RGB lookup; blanks to black when en is low.
module nes_rgb_rom
  import ppu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  code,
  input  logic        en,
  output logic [23:0] rgb
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rgb <= '0;
    else       rgb <= en ? NES_RGB[code] : '0;
  end

endmodule

// File: rtl/ppu_palette_out.sv
// PPU palette RAM, raster timing and two-stage index->RGB output pipeline.
// Optional macro PPU_PAL_GRAYSCALE_EN masks colour codes to 0x30 while grayscale=1.
module ppu_palette_out
  import ppu_pkg::*;
#(
  parameter int OUT_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  pal_index,
  input  logic        pal_wr,
  input  logic [4:0]  pal_addr,
  input  logic [5:0]  pal_wdata,
  output logic [5:0]  pal_rdata,
  input  logic        grayscale,
  output logic [23:0] rgb,
  output logic        pix_valid,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  logic [8:0]            cyc, line;
  logic [5:0]            pal_ram [32];
  logic [5:0]            raw_code, code0, code1;
  logic                  vis0;
  pix_tag_t              tag0, tag1, tag2;
  logic [OUT_LATENCY:1]  vld_pipe;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc  <= '0;
      line <= LINES - 9'd1;
    end else if (cyc == CYCLES - 9'd1) begin
      cyc  <= '0;
      line <= (line == LINES - 9'd1) ? '0 : line + 9'd1;
    end else begin
      cyc  <= cyc + 9'd1;
    end
  end

  // Palette contents survive reset on purpose.
  always_ff @(posedge clock) begin
    if (pal_wr) pal_ram[pal_mirror(pal_addr)] <= pal_wdata;
  end

  assign pal_rdata = pal_ram[pal_mirror(pal_addr)];
  assign raw_code  = pal_ram[pal_lookup(pal_index)];

`ifdef PPU_PAL_GRAYSCALE_EN
  assign code0 = grayscale ? (raw_code & 6'h30) : raw_code;
`else
  logic unused_gray;
  assign unused_gray = grayscale;
  assign code0       = raw_code;
`endif

  assign vis0 = (cyc >= 9'd1) && (cyc <= VIS_W) && (line < VIS_LINES);

  always_comb begin
    tag0    = '0;
    tag0.x  = vis0 ? 8'(cyc - 9'd1) : '0;
    tag0.y  = vis0 ? line[7:0] : '0;
    tag0.hs = (cyc >= HSYNC_START) && (cyc <= HSYNC_END);
    tag0.vs = (line >= VSYNC_START) && (line <= VSYNC_END);
    tag0.fs = vis0 && (cyc == 9'd1) && (line == 9'd0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      code1    <= '0;
      tag1     <= '0;
      tag2     <= '0;
      vld_pipe <= '0;
    end else begin
      code1    <= code0;
      tag1     <= tag0;
      tag2     <= tag1;
      vld_pipe <= {vld_pipe[OUT_LATENCY-1:1], vis0};
    end
  end

  nes_rgb_rom u_rom (
    .clock (clock),
    .reset (reset),
    .code  (code1),
    .en    (vld_pipe[1]),
    .rgb   (rgb)
  );

  assign pix_valid   = vld_pipe[OUT_LATENCY];
  assign pix_x       = tag2.x;
  assign pix_y       = tag2.y;
  assign hsync       = tag2.hs;
  assign vsync       = tag2.vs;
  assign frame_start = tag2.fs;

endmodule

// File: tb/tb_ppu_palette_out.sv
// Bench for ppu_palette_out: vector table + scoreboard, frame statistics, mid-frame reset.
module tb_ppu_palette_out;

  localparam int FRAME = 341 * 262;
`ifdef PPU_PAL_GRAYSCALE_EN
  localparam logic [23:0] GRAY_EXP = 24'hF8F8F8;
`else
  localparam logic [23:0] GRAY_EXP = 24'h58D854;
`endif

  logic        clock = 0;
  logic        reset = 1;
  logic [4:0]  pal_index = 5'h01;
  logic        pal_wr = 0;
  logic [4:0]  pal_addr = 0;
  logic [5:0]  pal_wdata = 0;
  logic [5:0]  pal_rdata;
  logic        grayscale = 0;
  logic [23:0] rgb;
  logic        pix_valid;
  logic [7:0]  pix_x, pix_y;
  logic        hsync, vsync, frame_start;

  ppu_palette_out dut (
    .clock(clock), .reset(reset), .pal_index(pal_index), .pal_wr(pal_wr),
    .pal_addr(pal_addr), .pal_wdata(pal_wdata), .pal_rdata(pal_rdata),
    .grayscale(grayscale), .rgb(rgb), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  idx;
    logic        gray;
    logic        wr;
    logic [4:0]  waddr;
    logic [5:0]  wdata;
    logic [23:0] exp;
  } vec_t;

  typedef struct {
    int          due;
    logic [23:0] rgb;
  } sb_t;

  typedef struct packed {
    logic       vis;
    logic [7:0] x;
    logic [7:0] y;
    logic       hs;
    logic       vs;
    logic       fs;
  } exp_t;

  int   checks = 0, errors = 0;
  int   ncyc = 0, tmis = 0, win_n = 0;
  bit   win_go = 0;
  int   m_cyc, m_line;
  exp_t e1, e2;
  sb_t  sbq[$];
  vec_t vt[13];
  int   n_fs = 0, n_pv = 0, n_vs = 0, n_hs = 0, n_hs_rise = 0, bad_runs = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t tim(input int c, input int l);
    exp_t e;
    e.vis = (c >= 1) && (c <= 256) && (l < 240);
    e.x   = 8'(c - 1);
    e.y   = 8'(l);
    e.hs  = (c >= 280) && (c <= 304);
    e.vs  = (l >= 243) && (l <= 245);
    e.fs  = (c == 1) && (l == 0);
    return e;
  endfunction

  // Reference raster position and 2-cycle delayed expected timing flags.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cyc <= 0; m_line <= 261; e1 <= '0; e2 <= '0;
    end else begin
      e2 <= e1;
      e1 <= tim(m_cyc, m_line);
      if (m_cyc == 340) begin
        m_cyc  <= 0;
        m_line <= (m_line == 261) ? 0 : m_line + 1;
      end else m_cyc <= m_cyc + 1;
    end
  end

  always @(posedge clock) ncyc <= ncyc + 1;

  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (pix_valid !== e2.vis || hsync !== e2.hs || vsync !== e2.vs || frame_start !== e2.fs) tmis++;
      else if (e2.vis && (pix_x !== e2.x || pix_y !== e2.y)) tmis++;
      else if (!e2.vis && rgb !== 24'h0) tmis++;
    end
  end

  initial forever begin
    @(negedge clock);
    if (sbq.size() > 0 && sbq[0].due == ncyc) begin
      sb_t s;
      s = sbq.pop_front();
      check("vec_rgb", rgb, s.rgb);
      check("vec_valid", pix_valid, 1);
    end
  end

  initial begin
    bit prev = 0;
    int run = 0;
    wait (win_go);
    repeat (FRAME) begin
      @(negedge clock);
      win_n++;
      n_fs += frame_start;
      n_pv += pix_valid;
      n_vs += vsync;
      n_hs += hsync;
      if (hsync && !prev) n_hs_rise++;
      if (hsync) run++;
      else if (prev) begin
        if (run != 25) bad_runs++;
        run = 0;
      end
      prev = hsync;
    end
  end

  task automatic pal_write(input logic [4:0] a, input logic [5:0] d);
    @(negedge clock);
    pal_wr = 1; pal_addr = a; pal_wdata = d;
    @(negedge clock);
    pal_wr = 0;
  endtask

  task automatic rd_check(input logic [4:0] a, input logic [5:0] d);
    pal_addr = a;
    #1;
    check($sformatf("rdata_%0h", a), pal_rdata, d);
  endtask

  task automatic wait_pos(input int l, input int c, input string nm);
    int g = 0;
    do begin
      @(posedge clock); #1; g++;
    end while (!(m_line == l && m_cyc == c) && g < 95000);
    if (g >= 95000) begin
      checks++; errors++;
      $display("FAIL %s: position %0d/%0d not reached, required %0d/%0d", nm, m_line, m_cyc, l, c);
    end
  endtask

  initial begin
    int n;
    vt[0]  = '{5'h01, 1'b0, 1'b0, 5'h00, 6'h00, 24'hF83800};
    vt[1]  = '{5'h14, 1'b0, 1'b0, 5'h00, 6'h00, 24'h3CBCFC};
    vt[2]  = '{5'h00, 1'b0, 1'b0, 5'h00, 6'h00, 24'h3CBCFC};
    vt[3]  = '{5'h1C, 1'b0, 1'b0, 5'h00, 6'h00, 24'h3CBCFC};
    vt[4]  = '{5'h02, 1'b1, 1'b0, 5'h00, 6'h00, GRAY_EXP};
    vt[5]  = '{5'h02, 1'b0, 1'b0, 5'h00, 6'h00, 24'h58D854};
    vt[6]  = '{5'h05, 1'b0, 1'b1, 5'h05, 6'h30, 24'hA81000};
    vt[7]  = '{5'h05, 1'b0, 1'b0, 5'h00, 6'h00, 24'hFCFCFC};
    vt[8]  = '{5'h1D, 1'b0, 1'b0, 5'h00, 6'h00, 24'h00FCFC};
    vt[9]  = '{5'h01, 1'b0, 1'b1, 5'h13, 6'h0F, 24'hF83800};
    vt[10] = '{5'h13, 1'b0, 1'b0, 5'h00, 6'h00, 24'h000000};
    vt[11] = '{5'h01, 1'b0, 1'b1, 5'h14, 6'h2D, 24'hF83800};
    vt[12] = '{5'h04, 1'b0, 1'b0, 5'h00, 6'h00, 24'h3CBCFC};

    repeat (2) @(negedge clock);
    check("rst_rgb", rgb, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_xy", {pix_x, pix_y}, 0);
    check("rst_sync", {hsync, vsync, frame_start}, 0);

    // Writes issued while reset is held must still land.
    pal_write(5'h01, 6'h16);
    pal_write(5'h10, 6'h21);
    pal_write(5'h02, 6'h2A);
    pal_write(5'h05, 6'h06);
    pal_write(5'h1D, 6'h3C);
    rd_check(5'h01, 6'h16);
    rd_check(5'h00, 6'h21);
    rd_check(5'h10, 6'h21);
    rd_check(5'h1D, 6'h3C);
    rd_check(5'h05, 6'h06);

    @(negedge clock);
    reset = 0;
    win_go = 1;

    wait_pos(0, 10, "reach_line0");
    for (int i = 0; i < 13; i++) begin
      pal_index = vt[i].idx; grayscale = vt[i].gray;
      pal_wr = vt[i].wr; pal_addr = vt[i].waddr; pal_wdata = vt[i].wdata;
      sbq.push_back('{ncyc + 2, vt[i].exp});
      @(posedge clock); #1;
    end
    pal_wr = 0; pal_index = 5'h01; grayscale = 0;
    repeat (4) @(negedge clock);
    check("sb_drain", sbq.size(), 0);
    rd_check(5'h04, 6'h2D);
    rd_check(5'h14, 6'h2D);
    rd_check(5'h00, 6'h21);
    rd_check(5'h13, 6'h0F);

    wait (win_n == FRAME);
    check("frame_starts", n_fs, 1);
    check("valid_cycles", n_pv, 61440);
    check("vsync_cycles", n_vs, 3 * 341);
    check("hsync_cycles", n_hs, 262 * 25);
    check("hsync_pulses", n_hs_rise, 262);
    check("hsync_bad_len", bad_runs, 0);

    wait_pos(2, 50, "reach_mid");
    check("mid_valid", pix_valid, 1);
    check("mid_rgb", rgb, 24'hF83800);
    #2 reset = 1;
    #1;
    check("async_rgb", rgb, 0);
    check("async_valid", pix_valid, 0);
    check("async_xy", {pix_x, pix_y}, 0);
    check("async_sync", {hsync, vsync, frame_start}, 0);
    repeat (3) @(negedge clock);
    reset = 0;
    n = 0;
    do begin
      @(negedge clock); n++;
    end while (pix_valid !== 1'b1 && n < 1000);
    check("first_valid_delay", n, 344);
    check("first_fs", frame_start, 1);
    check("first_xy", {pix_x, pix_y}, 0);
    repeat (5) @(negedge clock);
    check("timing_mismatches", tmis, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
